flash_read_arbiter: RTL and testbench



---
 rtl/flash_read_arbiter_if.sv | 46 ++++
 rtl/flash_read_arbiter.sv | 140 ++++++++++++++
 tb/tb_flash_read_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_read_arbiter_if.sv
// flash_read_arbiter_if
//   Bundles the two requester ports and the Avalon-MM style flash read bus
//   that the flash read arbiter sits between.
//
//   Requester side : req0/addr0 (audio playback), req1/addr1 (auxiliary),
//                    done0/done1 completion pulses, shared rdata/err, busy.
//   Flash side     : flash_read, flash_address, flash_byteenable (commands),
//                    flash_waitrequest, flash_readdata, flash_readdatavalid.
//
//   modport master : the arbiter itself; it masters the flash bus and
//                    answers the requesters.
//   modport slave  : everything around the arbiter (requesters plus flash).
interface flash_read_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              flash_read;
  logic [ADDR_W-1:0] flash_address;
  logic [3:0]        flash_byteenable;
  logic              flash_waitrequest;
  logic [DATA_W-1:0] flash_readdata;
  logic              flash_readdatavalid;

  modport master (
    input  req0, addr0, req1, addr1,
    input  flash_waitrequest, flash_readdata, flash_readdatavalid,
    output done0, done1, rdata, err, busy,
    output flash_read, flash_address, flash_byteenable
  );

  modport slave (
    output req0, addr0, req1, addr1,
    output flash_waitrequest, flash_readdata, flash_readdatavalid,
    input  done0, done1, rdata, err, busy,
    input  flash_read, flash_address, flash_byteenable
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter
//   Shares one external flash between two read requesters. Grants are
//   round-robin, only one read is in flight at a time, and a read that
//   never returns data is aborted after TIMEOUT_CYCLES with err set.
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high reset
//     bus    - flash_read_arbiter_if.master (requester ports + flash bus)
//
//   Parameters:
//     ADDR_W         - flash word-address width
//     DATA_W         - flash data width
//     TIMEOUT_CYCLES - cycles from ISSUE entry until a hung read is aborted
//                      (2 .. 65535)
module flash_read_arbiter #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  flash_read_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } state_t;

  // The counter value seen in the cycle just before it would reach
  // TIMEOUT_CYCLES; acting on it there lands DONE on the timeout cycle.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            state_q;
  logic              lastGrant_q;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cnt_q;
  logic              read_q;
  logic              done0_q;
  logic              done1_q;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] rdata_q;

  logic grant1;
  logic timeoutHit;

  // Port 1 wins when it is the only requester, or when both request and
  // port 0 had the previous grant.
  always_comb begin
    grant1     = bus.req1 && (!bus.req0 || !lastGrant_q);
    timeoutHit = (cnt_q == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      port_q      <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      read_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            port_q      <= grant1;
            lastGrant_q <= grant1;
            addr_q      <= grant1 ? bus.addr1 : bus.addr0;
            cnt_q       <= '0;
            read_q      <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + 16'd1;
          if (timeoutHit) begin
            read_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b1;
            done0_q <= !port_q;
            done1_q <= port_q;
            state_q <= DONE;
          end else if (!bus.flash_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          cnt_q <= cnt_q + 16'd1;
          // Data that arrives on the timeout cycle is still a good read.
          if (bus.flash_readdatavalid) begin
            rdata_q <= bus.flash_readdata;
            done0_q <= !port_q;
            done1_q <= port_q;
            state_q <= DONE;
          end else if (timeoutHit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            done0_q <= !port_q;
            done1_q <= port_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.done0            = done0_q;
  assign bus.done1            = done1_q;
  assign bus.rdata            = rdata_q;
  assign bus.err              = err_q;
  assign bus.busy             = busy_q;
  assign bus.flash_read       = read_q;
  assign bus.flash_address    = addr_q;
  assign bus.flash_byteenable = 4'b1111;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter
//   Directed bench for flash_read_arbiter with a small behavioural flash
//   slave whose waitrequest length, read latency and data are set per step.
module tb_flash_read_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done0Count = 0;
  int   done1Count = 0;

  // Flash model configuration and state
  int          cfgWait = 0;
  int          cfgLat = 1;
  bit          cfgRespond = 1'b1;
  bit          cfgMix = 1'b0;
  logic [31:0] cfgData = '0;
  bit          injectValid = 1'b0;
  int          holdCnt = 0;
  int          latCnt = 0;
  bit          pending = 1'b0;
  logic [22:0] acceptedAddr = '0;

  flash_read_arbiter_if #(.ADDR_W(23), .DATA_W(32)) bus ();

  flash_read_arbiter #(
    .ADDR_W(23),
    .DATA_W(32),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Flash slave: reacts on the falling edge so the arbiter sees stable
  // waitrequest/readdatavalid at its rising edge.
  always @(negedge clk) begin
    bus.flash_readdatavalid = 1'b0;
    if (pending) begin
      if (latCnt <= 1) begin
        bus.flash_readdatavalid = 1'b1;
        bus.flash_readdata = cfgMix ? (cfgData ^ {9'b0, acceptedAddr}) : cfgData;
        pending = 1'b0;
      end else begin
        latCnt = latCnt - 1;
      end
    end else if (injectValid) begin
      bus.flash_readdatavalid = 1'b1;
      bus.flash_readdata = 32'hDEADBEEF;
      injectValid = 1'b0;
    end
    if (bus.flash_read) begin
      if (holdCnt < cfgWait) begin
        bus.flash_waitrequest = 1'b1;
        holdCnt = holdCnt + 1;
      end else begin
        bus.flash_waitrequest = 1'b0;
        holdCnt = 0;
        acceptedAddr = bus.flash_address;
        if (cfgRespond) begin
          pending = 1'b1;
          latCnt = cfgLat;
        end
      end
    end else begin
      bus.flash_waitrequest = 1'b1;
      holdCnt = 0;
    end
  end

  // Tally completion pulses shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (bus.done0) done0Count = done0Count + 1;
    if (bus.done1) done1Count = done1Count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [22:0] a0,
                               input logic r1, input logic [22:0] a1);
    bus.req0 = r0;
    bus.addr0 = a0;
    bus.req1 = r1;
    bus.addr1 = a1;
  endtask

  task automatic setModel(input int w, input int lat, input bit respond,
                          input bit mix, input logic [31:0] data);
    cfgWait = w;
    cfgLat = lat;
    cfgRespond = respond;
    cfgMix = mix;
    cfgData = data;
  endtask

  // Waits (bounded) for a done pulse; also checks the flash address stays
  // at expAddr whenever the arbiter is busy.
  task automatic waitDone(input string tag, input int maxCyc, input logic [22:0] expAddr,
                          output int port, output logic [31:0] data,
                          output logic e, output int cyc);
    int badAddr;
    bit seen;
    badAddr = 0;
    seen = 1'b0;
    cyc = 0;
    port = -1;
    data = '0;
    e = 1'b0;
    while (!seen && cyc < maxCyc) begin
      @(negedge clk);
      cyc++;
      if (bus.busy && bus.flash_address !== expAddr) badAddr++;
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        port = bus.done1 ? 1 : 0;
        data = bus.rdata;
        e = bus.err;
      end
    end
    checkOutput({tag, ".doneSeen"}, 32'(seen), 32'd1);
    checkOutput({tag, ".addrStable"}, badAddr, 32'd0);
  endtask

  initial begin
    int          port;
    int          cyc;
    logic [31:0] data;
    logic        e;

    applyStimulus(1'b0, '0, 1'b0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.done0", 32'(bus.done0), 32'd0);
    checkOutput("rst.done1", 32'(bus.done1), 32'd0);
    checkOutput("rst.err", 32'(bus.err), 32'd0);
    checkOutput("rst.busy", 32'(bus.busy), 32'd0);
    checkOutput("rst.flashRead", 32'(bus.flash_read), 32'd0);
    checkOutput("rst.rdata", bus.rdata, 32'd0);
    checkOutput("rst.addr", 32'(bus.flash_address), 32'd0);
    checkOutput("rst.byteen", 32'(bus.flash_byteenable), 32'hF);
    reset = 1'b0;

    // Single read, waitrequest held 2 cycles, data 2 cycles after accept;
    // req0 dropped right after the grant.
    setModel(2, 2, 1'b1, 1'b0, 32'hA5A51234);
    applyStimulus(1'b1, 23'h000010, 1'b0, '0);
    @(negedge clk);
    checkOutput("t1.flashRead", 32'(bus.flash_read), 32'd1);
    checkOutput("t1.addr", 32'(bus.flash_address), 32'h10);
    applyStimulus(1'b0, 23'h000010, 1'b0, '0);
    waitDone("t1", 20, 23'h000010, port, data, e, cyc);
    checkOutput("t1.port", port, 32'd0);
    checkOutput("t1.rdata", data, 32'hA5A51234);
    checkOutput("t1.err", 32'(e), 32'd0);
    checkOutput("t1.latency", cyc, 32'd5);
    @(negedge clk);
    checkOutput("t1.pulseEnd", 32'(bus.done0), 32'd0);
    checkOutput("t1.idleBusy", 32'(bus.busy), 32'd0);
    checkOutput("t1.rdataHeld", bus.rdata, 32'hA5A51234);
    checkOutput("t1.done0Count", done0Count, 32'd1);
    checkOutput("t1.done1Count", done1Count, 32'd0);

    // Simultaneous first requests after reset: port 0 first.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    setModel(0, 1, 1'b1, 1'b1, 32'h0F0F0000);
    applyStimulus(1'b1, 23'h000100, 1'b1, 23'h7FFFFF);
    waitDone("t2a", 10, 23'h000100, port, data, e, cyc);
    checkOutput("t2a.port", port, 32'd0);
    checkOutput("t2a.rdata", data, 32'h0F0F0100);
    checkOutput("t2a.latency", cyc, 32'd3);
    applyStimulus(1'b0, 23'h000100, 1'b1, 23'h7FFFFF);
    waitDone("t2b", 10, 23'h7FFFFF, port, data, e, cyc);
    checkOutput("t2b.port", port, 32'd1);
    checkOutput("t2b.rdata", data, 32'h0F70FFFF);
    checkOutput("t2b.err", 32'(e), 32'd0);
    checkOutput("t2b.latency", cyc, 32'd4);
    applyStimulus(1'b0, 23'h000100, 1'b0, 23'h7FFFFF);
    @(negedge clk);
    checkOutput("t2.done0Count", done0Count, 32'd2);
    checkOutput("t2.done1Count", done1Count, 32'd1);

    // Fairness: both held for six reads, port 1 had the last grant.
    applyStimulus(1'b1, 23'h000100, 1'b1, 23'h7FFFFF);
    for (int i = 0; i < 6; i++) begin
      waitDone($sformatf("t3[%0d]", i), 10, (i % 2 == 0) ? 23'h000100 : 23'h7FFFFF,
               port, data, e, cyc);
      checkOutput($sformatf("t3[%0d].port", i), port, 32'(i % 2));
      checkOutput($sformatf("t3[%0d].rdata", i), data,
                  (i % 2 == 0) ? 32'h0F0F0100 : 32'h0F70FFFF);
      checkOutput($sformatf("t3[%0d].latency", i), cyc, (i == 0) ? 32'd3 : 32'd4);
    end
    applyStimulus(1'b0, 23'h000100, 1'b0, 23'h7FFFFF);
    @(negedge clk);
    checkOutput("t3.done0Count", done0Count, 32'd5);
    checkOutput("t3.done1Count", done1Count, 32'd4);

    // Timeout: flash accepts but never returns data (TIMEOUT_CYCLES=20).
    setModel(0, 1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 23'h000040, 1'b0, '0);
    waitDone("t4", 30, 23'h000040, port, data, e, cyc);
    checkOutput("t4.port", port, 32'd0);
    checkOutput("t4.err", 32'(e), 32'd1);
    checkOutput("t4.rdata", data, 32'd0);
    checkOutput("t4.latencyWindow", 32'(cyc >= 20 && cyc <= 22), 32'd1);
    applyStimulus(1'b0, 23'h000040, 1'b0, '0);
    @(negedge clk);
    checkOutput("t4.flashRead", 32'(bus.flash_read), 32'd0);
    checkOutput("t4.errPulse", 32'(bus.err), 32'd0);
    checkOutput("t4.busy", 32'(bus.busy), 32'd0);
    injectValid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t4.lateDone0", done0Count, 32'd6);
    checkOutput("t4.lateDone1", done1Count, 32'd4);
    checkOutput("t4.lateRdata", bus.rdata, 32'd0);
    checkOutput("t4.lateBusy", 32'(bus.busy), 32'd0);

    // Reset during WAIT_DATA: read discarded, then port 1 reads normally.
    setModel(0, 3, 1'b1, 1'b1, 32'h12340000);
    applyStimulus(1'b0, '0, 1'b1, 23'h000055);
    @(negedge clk);
    checkOutput("t5.issueBusy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput("t5.waitBusy", 32'(bus.busy), 32'd1);
    checkOutput("t5.waitRead", 32'(bus.flash_read), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("t5.rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("t5.rstRead", 32'(bus.flash_read), 32'd0);
    checkOutput("t5.rstDone1", 32'(bus.done1), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t5.noDone1", done1Count, 32'd4);
    checkOutput("t5.noDone0", done0Count, 32'd6);
    setModel(0, 1, 1'b1, 1'b1, 32'h12340000);
    applyStimulus(1'b0, '0, 1'b1, 23'h000066);
    waitDone("t5", 10, 23'h000066, port, data, e, cyc);
    checkOutput("t5.port", port, 32'd1);
    checkOutput("t5.rdata", data, 32'h12340066);
    checkOutput("t5.err", 32'(e), 32'd0);
    checkOutput("t5.latency", cyc, 32'd3);
    applyStimulus(1'b0, '0, 1'b0, 23'h000066);
    @(negedge clk);

    // Address stability: addr0 changes one cycle after the grant.
    setModel(1, 2, 1'b1, 1'b1, 32'h00AB0000);
    applyStimulus(1'b1, 23'h000020, 1'b0, '0);
    @(negedge clk);
    checkOutput("t6.issueAddr", 32'(bus.flash_address), 32'h20);
    applyStimulus(1'b1, 23'h000030, 1'b0, '0);
    waitDone("t6", 10, 23'h000020, port, data, e, cyc);
    checkOutput("t6.port", port, 32'd0);
    checkOutput("t6.rdata", data, 32'h00AB0020);
    checkOutput("t6.err", 32'(e), 32'd0);
    checkOutput("t6.latency", cyc, 32'd4);
    applyStimulus(1'b0, 23'h000030, 1'b0, '0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
